// File: rtl/food_position_generator_if.sv
// Request/query/result bundle between the food generator and its neighbours.
// The slave side is the generator; the master side is the game logic together
// with the snake-body occupancy store.
interface food_position_generator_if #(
  parameter int HW = 6,
  parameter int VW = 5
);
  logic          Request;
  logic          Busy;
  logic          QueryValid;
  logic [VW-1:0] QueryV;
  logic [HW-1:0] QueryH;
  logic          QueryOccupied;
  logic          FoodValid;
  logic          Failed;
  logic [VW-1:0] FoodV;
  logic [HW-1:0] FoodH;

  modport master (
    output Request, QueryOccupied,
    input  Busy, QueryValid, QueryV, QueryH, FoodValid, Failed, FoodV, FoodH
  );

  modport slave (
    input  Request, QueryOccupied,
    output Busy, QueryValid, QueryV, QueryH, FoodValid, Failed, FoodV, FoodH
  );
endinterface

// File: rtl/food_position_generator.sv
// Food cell generator for the snake playfield. A free-running Galois LFSR,
// stirred by synchronised oscillator bits and button presses, supplies
// candidate cells; out-of-range candidates are dropped, in-range ones are
// checked against the snake-body store, and after MAX_TRIES rejections the
// draw ends with Failed set and the previous food left in place.
// LFSR_WIDTH must cover both HW+VW and ENTROPY_BITS+5.
module food_position_generator #(
  parameter int                    GRID_W       = 40,
  parameter int                    GRID_H       = 30,
  parameter int                    LFSR_WIDTH   = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED         = 16'hACE1,
  parameter int                    ENTROPY_BITS = 2,
  parameter int                    MAX_TRIES    = 64
) (
  input  logic                    MasterClock,
  input  logic                    reset,
  input  logic [ENTROPY_BITS-1:0] EntropyIn,
  input  logic [4:0]              Buttons,
  food_position_generator_if.slave bus
);
  localparam int HW = $clog2(GRID_W);
  localparam int VW = $clog2(GRID_H);
  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_QUERY, S_WAIT} state_t;

  state_t                  r_state;
  logic [LFSR_WIDTH-1:0]   r_lfsr;
  logic [4:0]              r_buttons_q;
  logic [TW-1:0]           r_tries;
  logic                    r_busy;
  logic                    r_query_valid;
  logic [VW-1:0]           r_query_v;
  logic [HW-1:0]           r_query_h;
  logic                    r_food_valid;
  logic                    r_failed;
  logic [VW-1:0]           r_food_v;
  logic [HW-1:0]           r_food_h;

  logic [ENTROPY_BITS-1:0] w_ent_sync;
  logic [4:0]              w_button_rise;
  logic [LFSR_WIDTH-1:0]   w_lfsr_shift;
  logic [LFSR_WIDTH-1:0]   w_lfsr_mixed;
  logic [LFSR_WIDTH-1:0]   w_lfsr_next;
  logic [HW-1:0]           w_cand_h;
  logic [VW-1:0]           w_cand_v;
  logic                    w_cand_ok;
  logic                    w_tries_last;
  logic                    w_tries_full;
  logic [TW-1:0]           w_tries_inc;
  logic                    w_fail;

  // Two-flop synchroniser per oscillator bit; the bits are unrelated to MasterClock.
  genvar gi;
  generate
    for (gi = 0; gi < ENTROPY_BITS; gi++) begin : g_ent_sync
      logic r_meta;
      logic r_sync;
      // Metastability filter for one entropy bit.
      always_ff @(posedge MasterClock) begin
        if (reset) begin
          r_meta <= 1'b0;
          r_sync <= 1'b0;
        end else begin
          r_meta <= EntropyIn[gi];
          r_sync <= r_meta;
        end
      end
      assign w_ent_sync[gi] = r_sync;
    end
  endgenerate

  // Galois step, then entropy into the low bits and button edges just above them.
  assign w_button_rise = Buttons & ~r_buttons_q;
  assign w_lfsr_shift  = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
  assign w_lfsr_mixed  = w_lfsr_shift ^ LFSR_WIDTH'({w_button_rise, w_ent_sync});
  // The all-zero state would lock the LFSR, so it is replaced by the seed.
  assign w_lfsr_next   = (w_lfsr_mixed == '0) ? SEED : w_lfsr_mixed;

  // Candidate cell taken straight from the current LFSR state.
  assign w_cand_h  = r_lfsr[HW-1:0];
  assign w_cand_v  = r_lfsr[HW +: VW];
  assign w_cand_ok = (int'(w_cand_h) < GRID_W) && (int'(w_cand_v) < GRID_H);

  // Tries counter saturates at MAX_TRIES; "last" means this rejection exhausts the budget.
  assign w_tries_full = (r_tries >= TW'(MAX_TRIES));
  assign w_tries_last = (r_tries >= TW'(MAX_TRIES - 1));
  assign w_tries_inc  = w_tries_full ? r_tries : r_tries + TW'(1);
  assign w_fail = ((r_state != S_IDLE) && w_tries_full) ||
                  (((r_state == S_DRAW) && !w_cand_ok) ||
                   ((r_state == S_WAIT) && bus.QueryOccupied)) && w_tries_last;

  // LFSR runs every cycle regardless of FSM state; button history for edge detection.
  always_ff @(posedge MasterClock) begin
    if (reset) begin
      r_lfsr      <= SEED;
      r_buttons_q <= '0;
    end else begin
      r_lfsr      <= w_lfsr_next;
      r_buttons_q <= Buttons;
    end
  end

  // Draw FSM with registered strobes and held food/query coordinates.
  always_ff @(posedge MasterClock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tries       <= '0;
      r_busy        <= 1'b0;
      r_query_valid <= 1'b0;
      r_query_v     <= '0;
      r_query_h     <= '0;
      r_food_valid  <= 1'b0;
      r_failed      <= 1'b0;
      r_food_v      <= '0;
      r_food_h      <= '0;
    end else begin
      r_query_valid <= 1'b0;
      r_food_valid  <= 1'b0;
      if (w_fail) begin
        r_state      <= S_IDLE;
        r_tries      <= TW'(MAX_TRIES);
        r_busy       <= 1'b0;
        r_food_valid <= 1'b1;
        r_failed     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.Request) begin
              r_tries <= '0;
              r_busy  <= 1'b1;
              r_state <= S_DRAW;
            end
          end
          S_DRAW: begin
            if (w_cand_ok) begin
              r_query_h     <= w_cand_h;
              r_query_v     <= w_cand_v;
              r_query_valid <= 1'b1;
              r_state       <= S_QUERY;
            end else begin
              r_tries <= w_tries_inc;
            end
          end
          S_QUERY: r_state <= S_WAIT;
          S_WAIT: begin
            if (!bus.QueryOccupied) begin
              r_food_v     <= r_query_v;
              r_food_h     <= r_query_h;
              r_food_valid <= 1'b1;
              r_failed     <= 1'b0;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_tries <= w_tries_inc;
              r_state <= S_DRAW;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.Busy       = r_busy;
  assign bus.QueryValid = r_query_valid;
  assign bus.QueryV     = r_query_v;
  assign bus.QueryH     = r_query_h;
  assign bus.FoodValid  = r_food_valid;
  assign bus.Failed     = r_failed;
  assign bus.FoodV      = r_food_v;
  assign bus.FoodH      = r_food_h;
endmodule

// File: tb/tb_food_position_generator.sv
// Directed bench for food_position_generator: reset, LFSR sequence, single
// draw timing, occupied retries, exhaustion, back-to-back requests, reset
// during a lookup and a long run with random entropy.
module tb_food_position_generator;
  localparam int          GRID_W = 40;
  localparam int          GRID_H = 30;
  localparam int          HW     = 6;
  localparam int          VW     = 5;
  localparam logic [15:0] TAPS   = 16'hB400;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] ent = '0;
  logic [4:0] btn = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int occ_mode = 0;
  int qv_base  = 0;
  int qv_total = 0;
  int q_bad    = 0;
  logic [10:0] q_bad_got = '0;
  logic [10:0] q_bad_exp = '0;
  logic [10:0] exp_last  = '0;
  logic [10:0] exp_food  = '0;

  // Reference LFSR with its own entropy synchroniser and button edge detector.
  logic [15:0] m_lfsr, m_prev;
  logic [1:0]  m_meta, m_sync;
  logic [4:0]  m_btn_q;

  food_position_generator_if #(.HW(HW), .VW(VW)) bus ();

  food_position_generator #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .LFSR_WIDTH(16), .TAPS(TAPS),
    .SEED(SEED), .ENTROPY_BITS(2), .MAX_TRIES(64)
  ) dut (
    .MasterClock(clk),
    .reset(rst),
    .EntropyIn(ent),
    .Buttons(btn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mstep(input logic [15:0] x, input logic [1:0] e,
                                        input logic [4:0] rise);
    logic [15:0] n;
    n = (x >> 1) ^ (x[0] ? TAPS : 16'h0000);
    n[1:0] = n[1:0] ^ e;
    n[6:2] = n[6:2] ^ rise;
    if (n == 16'h0000) n = SEED;
    return n;
  endfunction

  function automatic logic inrange(input logic [15:0] x);
    return (x[5:0] < 6'd40) && (x[10:6] < 5'd30);
  endfunction

  function automatic logic marked(input logic [5:0] h);
    return (int'(h) % 5) == 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr  <= SEED;
      m_prev  <= SEED;
      m_meta  <= '0;
      m_sync  <= '0;
      m_btn_q <= '0;
    end else begin
      m_prev  <= m_lfsr;
      m_lfsr  <= mstep(m_lfsr, m_sync, btn & ~m_btn_q);
      m_meta  <= ent;
      m_sync  <= m_meta;
      m_btn_q <= btn;
    end
  end

  // Occupancy store stand-in: answer driven from the mode and the held query cell.
  assign bus.QueryOccupied = (occ_mode == 1) ||
                             ((occ_mode == 2) && ((qv_total - qv_base) <= 2)) ||
                             ((occ_mode == 3) && marked(bus.QueryH));

  // Records each lookup and whether its cell matches the model candidate.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.QueryValid === 1'b1) begin
      qv_total <= qv_total + 1;
      exp_last <= m_prev[10:0];
      if ({bus.QueryV, bus.QueryH} !== m_prev[10:0]) begin
        q_bad     <= q_bad + 1;
        q_bad_got <= {bus.QueryV, bus.QueryH};
        q_bad_exp <= m_prev[10:0];
      end
    end
  end

  task automatic do_request();
    bus.Request = 1'b1;
    @(negedge clk);
    bus.Request = 1'b0;
  endtask

  task automatic wait_food(input int limit, output int cyc);
    cyc = 1;
    while (bus.FoodValid !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ent = '0; btn = '0; bus.Request = 1'b0; occ_mode = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.Busy, bus.QueryValid, bus.FoodValid, bus.Failed} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000", {bus.Busy, bus.QueryValid, bus.FoodValid, bus.Failed});
    else n_pass++;
    n_checks++;
    if ({bus.FoodV, bus.FoodH} !== 11'd0) $display("FAIL reset_food: got %h expected 0", {bus.FoodV, bus.FoodH});
    else n_pass++;
    n_checks++;
    if ({bus.QueryV, bus.QueryH} !== 11'd0) $display("FAIL reset_query: got %h expected 0", {bus.QueryV, bus.QueryH});
    else n_pass++;
    n_checks++;
    if (dut.r_lfsr !== 16'hACE1) $display("FAIL reset_lfsr: got %h expected ace1", dut.r_lfsr);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_lfsr_sequence();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut.r_lfsr !== m_lfsr) $display("FAIL lfsr_seq[%0d]: got %h expected %h", i, dut.r_lfsr, m_lfsr);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    logic [15:0] x;
    int r, cyc, busy_bad, qb, q0;
    occ_mode = 0; qb = qv_total; q0 = q_bad;
    do_request();
    x = m_lfsr; r = 0;
    while (!inrange(x) && r < 60) begin x = mstep(x, 2'b00, 5'b00000); r++; end
    cyc = 1; busy_bad = 0;
    while (bus.FoodValid !== 1'b1 && cyc < 200) begin
      if (bus.Busy !== 1'b1) busy_bad++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc !== 4 + r) $display("FAIL single_latency: FoodValid in cycle %0d expected %0d", cyc, 4 + r);
    else n_pass++;
    n_checks++;
    if (busy_bad !== 0) $display("FAIL single_busy: %0d cycles low expected 0", busy_bad);
    else n_pass++;
    n_checks++;
    if ({bus.Busy, bus.Failed} !== 2'b00) $display("FAIL single_flags: busy,failed=%b expected 00", {bus.Busy, bus.Failed});
    else n_pass++;
    n_checks++;
    if ({bus.FoodV, bus.FoodH} !== x[10:0]) $display("FAIL single_food: got %h expected %h", {bus.FoodV, bus.FoodH}, x[10:0]);
    else n_pass++;
    n_checks++;
    if (!(bus.FoodH < 6'd40 && bus.FoodV < 5'd30)) $display("FAIL single_range: H=%0d V=%0d expected H<40 V<30", bus.FoodH, bus.FoodV);
    else n_pass++;
    n_checks++;
    if ((qv_total - qb) !== 1 || q_bad !== q0) $display("FAIL single_query: lookups=%0d bad=%0d expected 1 and 0", qv_total - qb, q_bad - q0);
    else n_pass++;
    exp_food = x[10:0];
    @(negedge clk);
    n_checks++;
    if (bus.FoodValid !== 1'b0) $display("FAIL single_pulse: FoodValid=%b expected 0", bus.FoodValid);
    else n_pass++;
  endtask

  task automatic test_occupied_retry();
    int cyc, q0;
    occ_mode = 2; qv_base = qv_total; q0 = q_bad;
    do_request();
    wait_food(500, cyc);
    n_checks++;
    if (bus.FoodValid !== 1'b1) $display("FAIL retry_done: FoodValid=%b after %0d cycles expected 1", bus.FoodValid, cyc);
    else n_pass++;
    n_checks++;
    if (bus.Failed !== 1'b0) $display("FAIL retry_failed: got %b expected 0", bus.Failed);
    else n_pass++;
    n_checks++;
    if ((qv_total - qv_base) !== 3) $display("FAIL retry_lookups: got %0d expected 3", qv_total - qv_base);
    else n_pass++;
    n_checks++;
    if ({bus.FoodV, bus.FoodH} !== exp_last) $display("FAIL retry_food: got %h expected %h", {bus.FoodV, bus.FoodH}, exp_last);
    else n_pass++;
    n_checks++;
    if (q_bad !== q0) $display("FAIL retry_query_cell: got %h expected %h", q_bad_got, q_bad_exp);
    else n_pass++;
    exp_food = exp_last;
    occ_mode = 0;
    @(negedge clk);
  endtask

  task automatic test_failure();
    int cyc, nq;
    occ_mode = 1; qv_base = qv_total;
    do_request();
    wait_food(3000, cyc);
    nq = qv_total - qv_base;
    n_checks++;
    if (bus.FoodValid !== 1'b1) $display("FAIL fail_done: FoodValid=%b after %0d cycles expected 1", bus.FoodValid, cyc);
    else n_pass++;
    n_checks++;
    if ({bus.Failed, bus.Busy} !== 2'b10) $display("FAIL fail_flags: failed,busy=%b expected 10", {bus.Failed, bus.Busy});
    else n_pass++;
    n_checks++;
    if ({bus.FoodV, bus.FoodH} !== exp_food) $display("FAIL fail_food_kept: got %h expected %h", {bus.FoodV, bus.FoodH}, exp_food);
    else n_pass++;
    n_checks++;
    if (nq < 1 || nq > 64) $display("FAIL fail_lookups: got %0d expected 1..64", nq);
    else n_pass++;
    occ_mode = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.Failed, bus.FoodValid} !== 2'b10) $display("FAIL fail_hold: failed,foodvalid=%b expected 10", {bus.Failed, bus.FoodValid});
    else n_pass++;
    do_request();
    wait_food(500, cyc);
    n_checks++;
    if ({bus.FoodValid, bus.Failed} !== 2'b10) $display("FAIL fail_clear: foodvalid,failed=%b expected 10", {bus.FoodValid, bus.Failed});
    else n_pass++;
    n_checks++;
    if ({bus.FoodV, bus.FoodH} !== exp_last) $display("FAIL fail_next_food: got %h expected %h", {bus.FoodV, bus.FoodH}, exp_last);
    else n_pass++;
    exp_food = exp_last;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int accepted, fv, coinc, coinc_bad;
    logic prev_coinc;
    occ_mode = 0; accepted = 0; fv = 0; coinc = 0; coinc_bad = 0; prev_coinc = 1'b0;
    bus.Request = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (prev_coinc && bus.Busy !== 1'b1) coinc_bad++;
      if (bus.Busy === 1'b0) accepted++;
      if (bus.FoodValid === 1'b1) begin fv++; coinc++; end
      prev_coinc = (bus.FoodValid === 1'b1);
      @(negedge clk);
    end
    bus.Request = 1'b0;
    if (prev_coinc && bus.Busy !== 1'b1) coinc_bad++;
    for (int i = 0; i < 100; i++) begin
      if (bus.FoodValid === 1'b1) fv++;
      @(negedge clk);
    end
    n_checks++;
    if (fv !== accepted) $display("FAIL b2b_count: FoodValid pulses %0d expected %0d", fv, accepted);
    else n_pass++;
    n_checks++;
    if (coinc_bad !== 0) $display("FAIL b2b_coincident: %0d ignored expected 0", coinc_bad);
    else n_pass++;
    n_checks++;
    if (coinc < 2) $display("FAIL b2b_coverage: %0d coincident requests expected >=2", coinc);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    int cyc, fv, busy_seen;
    occ_mode = 0;
    do_request();
    cyc = 1;
    while (bus.QueryValid !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
    n_checks++;
    if (bus.QueryValid !== 1'b1) $display("FAIL rstwait_query: QueryValid=%b after %0d cycles expected 1", bus.QueryValid, cyc);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.Busy, bus.QueryValid, bus.FoodValid, bus.Failed, bus.FoodV, bus.FoodH, bus.QueryV, bus.QueryH} !== 26'd0)
      $display("FAIL rstwait_outputs: got %h expected 0",
               {bus.Busy, bus.QueryValid, bus.FoodValid, bus.Failed, bus.FoodV, bus.FoodH, bus.QueryV, bus.QueryH});
    else n_pass++;
    rst = 1'b0;
    fv = 0; busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.FoodValid === 1'b1) fv++;
      if (bus.Busy === 1'b1) busy_seen++;
      @(negedge clk);
    end
    n_checks++;
    if (fv !== 0 || busy_seen !== 0) $display("FAIL rstwait_abort: foodvalid=%0d busy=%0d expected 0 and 0", fv, busy_seen);
    else n_pass++;
    exp_food = '0;
  endtask

  task automatic test_random();
    int cyc, zero_seen, lfsr_bad, fails, q0;
    occ_mode = 3; zero_seen = 0; lfsr_bad = 0; fails = 0; q0 = q_bad;
    for (int k = 0; k < 1000; k++) begin
      ent = 2'($urandom_range(0, 3));
      btn = 5'($urandom_range(0, 31));
      do_request();
      cyc = 1;
      while (bus.FoodValid !== 1'b1 && cyc < 3000) begin
        if (dut.r_lfsr == 16'h0000) zero_seen++;
        if (dut.r_lfsr !== m_lfsr) lfsr_bad++;
        ent = 2'($urandom_range(0, 3));
        btn = 5'($urandom_range(0, 31));
        @(negedge clk);
        cyc++;
      end
      n_checks++;
      if (bus.FoodValid !== 1'b1) begin
        $display("FAIL rand_done[%0d]: FoodValid=%b after %0d cycles expected 1", k, bus.FoodValid, cyc);
      end else if (bus.Failed === 1'b1) begin
        fails++;
        if ({bus.FoodV, bus.FoodH} !== exp_food) $display("FAIL rand_kept[%0d]: got %h expected %h", k, {bus.FoodV, bus.FoodH}, exp_food);
        else n_pass++;
      end else if ({bus.FoodV, bus.FoodH} !== exp_last || !(bus.FoodH < 6'd40 && bus.FoodV < 5'd30) || marked(bus.FoodH)) begin
        $display("FAIL rand_food[%0d]: got %h expected free in-range %h", k, {bus.FoodV, bus.FoodH}, exp_last);
      end else begin
        n_pass++;
        exp_food = exp_last;
      end
    end
    ent = '0; btn = '0;
    n_checks++;
    if (zero_seen !== 0) $display("FAIL rand_lfsr_zero: %0d zero cycles expected 0", zero_seen);
    else n_pass++;
    n_checks++;
    if (lfsr_bad !== 0) $display("FAIL rand_lfsr_model: %0d mismatching cycles expected 0", lfsr_bad);
    else n_pass++;
    n_checks++;
    if (q_bad !== q0) $display("FAIL rand_query_cell: got %h expected %h", q_bad_got, q_bad_exp);
    else n_pass++;
    $display("random phase: 1000 requests, %0d exhausted draws", fails);
  endtask

  initial begin
    bus.Request = 1'b0;
    test_reset();
    test_lfsr_sequence();
    test_single();
    test_occupied_retry();
    test_failure();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
